// File: rtl/puf_scan_ctrl_pkg.sv
// Shared types and constants for the PUF array control blocks.
package puf_pkg;
  localparam int PUF_NUM_CELLS = 128;
  localparam int PUF_SEL_W     = 7;

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, GAP, DONE} puf_scan_state_e;
  typedef logic [PUF_SEL_W-1:0] puf_sel_t;

  // Strict majority of ones over an odd sample count.
  function automatic logic majority(int ones, int samples);
    return (ones * 2) > samples;
  endfunction
endpackage

// File: rtl/puf_scan_ctrl_if.sv
// Scan controller bus: start/abort handshake, cell drive and response.
interface puf_scan_ctrl_if import puf_pkg::*; #(
  parameter int NUM_CELLS = PUF_NUM_CELLS,
  parameter int SEL_W     = PUF_SEL_W
);
  logic                 start;
  logic                 abort;
  logic                 puf_bit;
  logic [SEL_W-1:0]     sel;
  logic                 cell_en;
  logic                 busy;
  logic                 done;
  logic                 valid;
  logic [NUM_CELLS-1:0] response;

  modport master (output start, abort, puf_bit,
                  input  sel, cell_en, busy, done, valid, response);
  modport slave  (input  start, abort, puf_bit,
                  output sel, cell_en, busy, done, valid, response);
endinterface

// File: rtl/puf_scan_ctrl_bit_sync.sv
// Flop-chain synchronizer for asynchronous PUF response bits.
module puf_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ff <= '0;
    end else begin
      ff[0] <= d;
      for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
    end
  end

  assign q = ff[STAGES-1];
endmodule

// File: rtl/puf_scan_ctrl.sv
// Sequences every PUF cell: enable, settle, majority-sample, store, gap.
module puf_scan_ctrl import puf_pkg::*; #(
  parameter int NUM_CELLS     = PUF_NUM_CELLS,
  parameter int SEL_W         = PUF_SEL_W,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 3,
  parameter int SYNC_STAGES   = 2
) (
  input logic            clk,
  input logic            rst,
  puf_scan_ctrl_if.slave bus
);
  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
  localparam int SM_W = $clog2(SAMPLES + 1);

  puf_scan_state_e      state;
  logic [SEL_W-1:0]     sel;
  logic                 cell_en, busy, done, valid;
  logic [NUM_CELLS-1:0] response;
  logic [SC_W-1:0]      settle_cnt;
  logic [SM_W-1:0]      smp_cnt, ones, ones_nxt;
  logic                 bit_s;

  puf_bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.puf_bit),
    .q   (bit_s)
  );

  assign ones_nxt = ones + SM_W'(bit_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sel        <= '0;
      cell_en    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      valid      <= 1'b0;
      response   <= '0;
      settle_cnt <= '0;
      smp_cnt    <= '0;
      ones       <= '0;
    end else begin
      done <= 1'b0;
      // busy is high exactly in SETTLE/SAMPLE/GAP, the abortable states
      if (busy && bus.abort) begin
        state      <= IDLE;
        sel        <= '0;
        cell_en    <= 1'b0;
        busy       <= 1'b0;
        settle_cnt <= '0;
        smp_cnt    <= '0;
        ones       <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start && !bus.abort) begin
              state      <= SETTLE;
              sel        <= '0;
              response   <= '0;
              valid      <= 1'b0;
              busy       <= 1'b1;
              cell_en    <= 1'b1;
              settle_cnt <= '0;
            end
          end
          SETTLE: begin
            if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) begin
              state      <= SAMPLE;
              settle_cnt <= '0;
              smp_cnt    <= '0;
              ones       <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          SAMPLE: begin
            if (smp_cnt == SM_W'(SAMPLES - 1)) begin
              response[sel] <= majority(int'(ones_nxt), SAMPLES);
              smp_cnt       <= '0;
              ones          <= '0;
              cell_en       <= 1'b0;
              if (sel == SEL_W'(NUM_CELLS - 1)) begin
                sel   <= '0;
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                valid <= 1'b1;
              end else begin
                // sel only moves while the cell is disabled
                sel   <= sel + 1'b1;
                state <= GAP;
              end
            end else begin
              smp_cnt <= smp_cnt + 1'b1;
              ones    <= ones_nxt;
            end
          end
          GAP: begin
            state   <= SETTLE;
            cell_en <= 1'b1;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.sel      = sel;
  assign bus.cell_en  = cell_en;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.valid    = valid;
  assign bus.response = response;
endmodule

// File: tb/tb_puf_scan_ctrl.sv
// Scoreboard bench for puf_scan_ctrl: directed scans, abort, reset, majority.
module tb_puf_scan_ctrl;
  import puf_pkg::*;

  localparam int LAT = 1535;
  localparam logic [127:0] ALL1 = {128{1'b1}};
  localparam logic [127:0] ALT  = {32{4'hA}};

  typedef struct {
    logic [127:0] resp;
    int           done_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   e0  = 0;
  int   mode = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];

  puf_scan_ctrl_if bus ();

  puf_scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Raw bit source; sample window j=6..8 lands on the three sample edges.
  initial begin
    int j;
    logic [2:0] pat;
    j = -1;
    bus.puf_bit = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.cell_en) j++; else j = -1;
      case (mode)
        0: bus.puf_bit = 1'b1;
        1: bus.puf_bit = bus.sel[0];
        default: begin
          case (bus.sel)
            7'd5:    pat = 3'b101;
            7'd6:    pat = 3'b010;
            7'd7:    pat = 3'b011;
            7'd8:    pat = 3'b110;
            7'd9:    pat = 3'b001;
            default: pat = 3'b000;
          endcase
          bus.puf_bit = (j >= 6 && j <= 8) ? pat[j-6] : 1'b0;
        end
      endcase
    end
  end

  // Monitor: completions against the scoreboard, plus select/gap sequencing.
  initial begin
    exp_t e;
    logic prev_en, have_prev;
    logic [6:0] last_sel;
    int low_len;
    prev_en = 0; have_prev = 0; last_sel = '0; low_len = 0;
    forever begin
      @(negedge clk);
      if (!rst && bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 128'(cyc), 128'(0));
        end else begin
          e = exp_q.pop_front();
          check("done_response", bus.response, e.resp);
          check("done_cycle", 128'(cyc), 128'(e.done_cyc));
          check("done_valid", 128'(bus.valid), 128'(1));
          check("done_busy", 128'(bus.busy), 128'(0));
        end
      end
      if (rst || !bus.busy) begin
        have_prev = 0; prev_en = 0; low_len = 0;
      end else begin
        if (bus.cell_en && !prev_en) begin
          if (have_prev) begin
            check("gap_len", 128'(low_len), 128'(1));
            check("sel_step", 128'(bus.sel), 128'(7'(last_sel + 1)));
          end
          have_prev = 1;
          last_sel  = bus.sel;
        end else if (bus.cell_en && bus.sel != last_sel) begin
          check("sel_stable", 128'(bus.sel), 128'(last_sel));
        end
        if (bus.cell_en) low_len = 0; else low_len++;
        prev_en = bus.cell_en;
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic do_start(bit push, logic [127:0] resp);
    exp_t e;
    pulse_start();
    e0 = cyc;
    if (push) begin
      e.resp = resp;
      e.done_cyc = e0 + LAT;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_until(int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) check("done_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 128'(bus.busy), 128'(0));
    check("rst_valid", 128'(bus.valid), 128'(0));
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_sel", 128'(bus.sel), 128'(0));
    check("idle_en", 128'(bus.cell_en), 128'(0));
    check("idle_done", 128'(bus.done), 128'(0));
    check("idle_resp", bus.response, 128'(0));

    // Constant ones
    mode = 0;
    do_start(1, ALL1);
    check("start_busy", 128'(bus.busy), 128'(1));
    check("start_en", 128'(bus.cell_en), 128'(1));
    check("start_valid", 128'(bus.valid), 128'(0));
    wait_done();
    // start while in DONE must be ignored
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("done_start_ignored", 128'(bus.busy), 128'(0));
    check("valid_held", 128'(bus.valid), 128'(1));

    // Alternating cells, with a start repeated mid-scan
    mode = 1;
    do_start(1, ALT);
    check("restart_clears_resp", bus.response, 128'(0));
    wait_until(e0 + 100);
    pulse_start();
    wait_done();

    // Majority patterns on cells 5..9
    mode = 2;
    do_start(1, 128'h1A0);
    wait_done();

    // Abort at E0+500: cells 0..40 already stored
    mode = 0;
    do_start(0, '0);
    wait_until(e0 + 499);
    @(negedge clk);
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    check("abort_busy", 128'(bus.busy), 128'(0));
    check("abort_en", 128'(bus.cell_en), 128'(0));
    check("abort_sel", 128'(bus.sel), 128'(0));
    check("abort_valid", 128'(bus.valid), 128'(0));
    check("abort_partial", bus.response, (128'd1 << 41) - 128'd1);
    wait_until(e0 + LAT + 10);

    do_start(1, ALL1);
    wait_done();

    // Start and abort together in IDLE
    @(negedge clk); @(negedge clk);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check("sa_busy", 128'(bus.busy), 128'(0));
    check("sa_en", 128'(bus.cell_en), 128'(0));
    check("sa_valid", 128'(bus.valid), 128'(1));
    repeat (20) @(posedge clk);
    #1;
    check("sa_still_idle", 128'(bus.busy), 128'(0));

    // Reset during cell 50 SAMPLE
    do_start(0, '0);
    wait_until(e0 + 12 * 50 + 9);
    check("pre_rst_sel", 128'(bus.sel), 128'(50));
    check("pre_rst_busy", 128'(bus.busy), 128'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_sel", 128'(bus.sel), 128'(0));
    check("mid_rst_en", 128'(bus.cell_en), 128'(0));
    check("mid_rst_busy", 128'(bus.busy), 128'(0));
    check("mid_rst_resp", bus.response, 128'(0));
    @(negedge clk);
    rst = 1'b0;
    wait_until(e0 + LAT + 20);
    check("final_busy", 128'(bus.busy), 128'(0));
    check("sb_empty", 128'(exp_q.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/puf_scan_ctrl.md
Name: puf_scan_ctrl

Overview:
- Sequencer for the 128-cell PUF array.
- Drives the 7-bit cell select into the one-hot cell decoder and gates cell enable.
- For each cell: waits a settle window, takes a majority vote over repeated samples of the response bit, and stores the result into a 128-bit response register.
- Sits between the PUF array and the key/ID logic. Start/done handshake; abort supported.

Parameters:
- NUM_CELLS, 128, number of PUF cells scanned; must equal 2**SEL_W.
- SEL_W, 7, width of the cell select.
- SETTLE_CYCLES, 8, cycles cell is enabled before first sample; must be >= SYNC_STAGES, >= 1.
- SAMPLES, 3, samples per cell for majority vote; odd, >= 1.
- SYNC_STAGES, 2, synchronizer flops on i_PufBit.

Ports:
- i_Clk  in  1  clock
- i_Rst  in  1  reset
- i_Start  in  1  start scan; accepted only in IDLE
- i_Abort  in  1  abort scan in progress
- o_Sel  out  SEL_W  cell select to decoder
- o_CellEn  out  1  cell enable (gates decoded select)
- i_PufBit  in  1  raw asynchronous PUF response bit
- o_Busy  out  1  scan in progress
- o_Done  out  1  one-cycle pulse on scan completion
- o_Valid  out  1  o_Response holds a complete scan
- o_Response  out  NUM_CELLS  response bits, bit k = cell k

Behaviour:
- Clocking/reset: one clock, i_Clk. Reset i_Rst is asynchronous and active-high.
- Reset values: all outputs and internal state zero; FSM in IDLE; synchronizer cleared.
- i_PufBit passes through SYNC_STAGES flops. All samples use the synchronized value.
- FSM states: IDLE, SETTLE, SAMPLE, GAP, DONE.
- IDLE:
  - i_Start=1 and i_Abort=0 at edge E0 -> SETTLE.
  - At that edge: o_Sel=0, o_Response cleared, o_Valid=0, o_Busy=1, settle counter cleared.
- SETTLE:
  - o_CellEn=1; count SETTLE_CYCLES cycles, then -> SAMPLE.
  - Ones-counter cleared on entry to SAMPLE.
- SAMPLE:
  - o_CellEn=1; sample the synced bit on each of SAMPLES consecutive edges and count ones.
  - On the last sample edge: o_Response[o_Sel] <= (ones including this sample)*2 > SAMPLES.
  - Same edge, if o_Sel != NUM_CELLS-1: o_Sel <= o_Sel+1, -> GAP.
  - Same edge, if last cell: o_Sel <= 0, -> DONE.
- GAP: o_CellEn=0 for exactly 1 cycle, then -> SETTLE.
- o_Sel never changes while o_CellEn=1.
- DONE:
  - o_Done=1 and o_Busy=0 for this single cycle, then -> IDLE.
  - o_Valid set on the edge entering DONE; held until next accepted start or reset.
- Latency:
  - Cell k is enabled from edge E0+k*(SETTLE_CYCLES+SAMPLES+1).
  - DONE entered at edge E0+NUM_CELLS*(SETTLE_CYCLES+SAMPLES+1)-1; defaults: E0+1535.
- o_Busy=1 in SETTLE/SAMPLE/GAP; 0 in IDLE/DONE.
- i_Start in any state other than IDLE is ignored. This includes DONE: a restart requires IDLE.
- i_Abort in SETTLE/SAMPLE/GAP, at the next edge:
  - -> IDLE; o_CellEn=0, o_Busy=0, o_Sel=0, counters cleared.
  - o_Valid stays 0; o_Done not pulsed; partial o_Response retained but not valid.
- i_Abort in IDLE/DONE: no effect (DONE still pulses).
- i_Start and i_Abort together in IDLE: abort wins, stay IDLE.
- Reset asserted mid-scan: immediate return to reset values; no o_Done.
- Counter widths:
  - settle counter: $clog2(SETTLE_CYCLES+1).
  - ones and sample counters: $clog2(SAMPLES+1).
  - No wrap-around is possible.

Decomposition:
- Package puf_pkg:
  - PUF_NUM_CELLS=128, PUF_SEL_W=7.
  - typedef enum logic [2:0] puf_scan_state_e {IDLE, SETTLE, SAMPLE, GAP, DONE}.
  - typedef logic [PUF_SEL_W-1:0] puf_sel_t.
- One sub-module puf_bit_sync: parameterized SYNC_STAGES flop chain with asynchronous active-high reset. Reused by other PUF blocks.
- FSM, counters and response register stay in puf_scan_ctrl.

Test Plan:
- Reset -> all outputs 0.
- Start pulse in IDLE, i_PufBit held 1, defaults:
  - o_Sel sweeps 0..127; o_CellEn low exactly one cycle between cells.
  - o_Done pulses once at E0+1535; o_Response all ones; o_Valid=1.
- Raw bit driven = o_Sel[0], stable per cell -> o_Response = 128'hAAAA...AAAA.
- Majority:
  - cell 5 synced samples 1,0,1 -> o_Response[5]=1.
  - cell 6 samples 0,1,0 -> o_Response[6]=0.
  - cell 7 samples 1,1,0 -> o_Response[7]=1.
- Abort at E0+500:
  - next cycle o_Busy=0, o_CellEn=0, o_Sel=0; no o_Done; o_Valid=0.
  - new Start then completes normally with o_Done at +1535.
- Start repeated while busy -> ignored, o_Done timing unchanged.
- Start+Abort same cycle in IDLE -> remains IDLE, o_Busy=0.
- Reset asserted mid-SAMPLE -> outputs zero immediately; no o_Done.
